// File: rtl/mult_pkg.sv
// Shared constants for the sequential multiplier: FSM state encoding and default width.
package mult_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_mult_ctrl_if.sv
// Operand/product handshake bundle between a producer/consumer and the multiplier.
interface seq_mult_ctrl_if #(
  parameter int WIDTH = mult_pkg::WIDTH_DEFAULT
);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out;
  logic               busy;

  // Side that supplies operands and consumes products.
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, out, busy
  );

  // The multiplier itself.
  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, out, busy
  );

endinterface

// File: rtl/seq_mult_ctrl_adder.sv
// Single shared accumulate adder: {cout, sum} = x + y + cin, purely combinational.
module mult_acc_adder #(
  parameter int W = 16
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  // Widen by one bit so the carry falls out of the top.
  always_comb begin
    {cout, sum} = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, cin};
  end

endmodule

// File: rtl/seq_mult_ctrl.sv
// Shift-add multiplier: one partial product per RUN cycle through a single shared adder.
module seq_mult_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  seq_mult_ctrl_if.slave  bus
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t          state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [PW-1:0]   acc_reg;
  logic [PW-1:0]   out_reg;
  logic [CW-1:0]   cnt_reg;
  logic            in_ready_reg;
  logic            out_valid_reg;
  logic            busy_reg;

  logic [PW-1:0]   addend;
  logic [PW-1:0]   acc_next;
  logic            adder_cout;

  // Partial product for the current bit: zero-extended multiplicand shifted into place, gated by a bit.
  always_comb begin
    addend = '0;
    if (a_reg[cnt_reg]) begin
      addend = {{WIDTH{1'b0}}, b_reg} << cnt_reg;
    end
  end

  mult_acc_adder #(.W(PW)) u_adder (
    .x    (acc_reg),
    .y    (addend),
    .cin  (1'b0),
    .sum  (acc_next),
    .cout (adder_cout)
  );

  // Controller FSM and datapath registers; handshake outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      acc_reg       <= '0;
      out_reg       <= '0;
      cnt_reg       <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.in_valid && in_ready_reg) begin
            a_reg        <= bus.a;
            b_reg        <= bus.b;
            acc_reg      <= '0;
            cnt_reg      <= '0;
            state_reg    <= ST_RUN;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
          end
        end
        ST_RUN: begin
          acc_reg <= acc_next;
          if (cnt_reg == CNT_LAST) begin
            out_reg       <= acc_next;
            state_reg     <= ST_DONE;
            out_valid_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state_reg     <= ST_IDLE;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            in_ready_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg     <= ST_IDLE;
          out_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
          in_ready_reg  <= 1'b1;
        end
      endcase
    end
  end

  // The product always fits in PW bits, so the adder must never carry out while accumulating.
  always_ff @(posedge clk) begin
    if (!rst && state_reg == ST_RUN) begin
      assert (!adder_cout) else $error("seq_mult_ctrl: accumulate adder carried out");
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out       = out_reg;
  assign bus.busy      = busy_reg;

endmodule
